// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// Holds the FSM state encoding, requester port ids and the range check helper.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W       = 9;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MEM_DEPTH    = 256;
  localparam int DEF_MAX_D_STREAK = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Words at or above the populated depth have no RAM behind them.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_grant_arb.sv
// Fetch/data winner select with a starvation guard: data has priority, but a
// waiting fetch is served after MAX_D_STREAK consecutive data grants.
module mem_grant_arb
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic i_clock,
  input  logic i_clear,
  input  logic i_grant_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_grant,
  output logic o_grant_port
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] r_streak;
  logic          w_streak_max;

  assign w_streak_max = (r_streak == SW'(MAX_D_STREAK));
  assign o_grant      = i_grant_en && (i_if_req || i_d_req);
  assign o_grant_port = (i_d_req && !(i_if_req && w_streak_max)) ? PORT_D : PORT_IF;

  // The streak only measures how long a fetch has been kept waiting.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_streak <= '0;
    end else if (!i_if_req) begin
      r_streak <= '0;
    end else if (o_grant) begin
      if (o_grant_port == PORT_D) begin
        r_streak <= r_streak + SW'(1);
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single-ported RAM between fetch and load/store requesters; owns the
// strobes, address and data bus so a write pulse always sees stable address/data.
//
//   state  | meaning
//   IDLE   | sample requests, latch winner's operands
//   READ   | mem_read high, RAM drives the bus
//   WSETUP | address/data driven, write low
//   WPULSE | write high
//   WHOLD  | write low, address/data still driven
//   ACK    | one-cycle ack (and err) to the winning port
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              i_clock,
  input  logic              i_clear,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic              o_if_err,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic              o_d_err,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [DATA_W-1:0] io_mem_data
);

  state_t            r_state;
  logic              r_port;
  logic              r_drive;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_if_ack;
  logic              r_if_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_grant;
  logic              w_grant_port;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic              w_sel_ok;

  mem_grant_arb #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_arb (
    .i_clock      (i_clock),
    .i_clear      (i_clear),
    .i_grant_en   (r_state == ST_IDLE),
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .o_grant      (w_grant),
    .o_grant_port (w_grant_port)
  );

  assign w_sel_addr = (w_grant_port == PORT_D) ? i_d_addr : i_if_addr;
  assign w_sel_we   = (w_grant_port == PORT_D) && i_d_we;
  assign w_sel_ok   = addr_in_range(32'(w_sel_addr), MEM_DEPTH);

  assign io_mem_data = r_drive ? r_wdata : {DATA_W{1'bz}};

  assign o_if_ack    = r_if_ack;
  assign o_if_err    = r_if_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_ack     = r_d_ack;
  assign o_d_err     = r_d_err;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state     <= ST_IDLE;
      r_port      <= PORT_IF;
      r_drive     <= 1'b0;
      r_wdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_if_ack    <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_port <= w_grant_port;
            if (!w_sel_ok) begin
              // Out-of-range: no RAM cycle at all, straight to an error ack.
              r_state <= ST_ACK;
              if (w_grant_port == PORT_D) begin
                r_d_ack   <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_if_ack   <= 1'b1;
                r_if_err   <= 1'b1;
                r_if_rdata <= '0;
              end
            end else begin
              r_mem_addr <= w_sel_addr;
              if (w_sel_we) begin
                r_wdata <= i_d_wdata;
                r_drive <= 1'b1;
                r_state <= ST_WSETUP;
              end else begin
                r_mem_read <= 1'b1;
                r_state    <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          r_mem_read <= 1'b0;
          r_state    <= ST_ACK;
          if (r_port == PORT_D) begin
            r_d_ack   <= 1'b1;
            r_d_rdata <= io_mem_data;
          end else begin
            r_if_ack   <= 1'b1;
            r_if_rdata <= io_mem_data;
          end
        end
        ST_WSETUP: begin
          r_mem_write <= 1'b1;
          r_state     <= ST_WPULSE;
        end
        ST_WPULSE: begin
          r_mem_write <= 1'b0;
          r_state     <= ST_WHOLD;
        end
        ST_WHOLD: begin
          // Only the data port can store, so the ack always goes there.
          r_drive <= 1'b0;
          r_d_ack <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_if_ack <= 1'b0;
          r_if_err <= 1'b0;
          r_d_ack  <= 1'b0;
          r_d_err  <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-latency reference model checked every
// cycle, directed literal cases, then randomized two-requester traffic.
module tb_mem_access_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int MAXS  = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          o_if_ack, o_if_err, o_d_ack, o_d_err;
  logic [DW-1:0] o_if_rdata, o_d_rdata;
  logic          o_mem_read, o_mem_write;
  logic [AW-1:0] o_mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MAX_D_STREAK(MAXS)
  ) dut (
    .i_clock(clock), .i_clear(clear),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ack(o_if_ack), .o_if_err(o_if_err), .o_if_rdata(o_if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(o_d_ack), .o_d_err(o_d_err), .o_d_rdata(o_d_rdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .io_mem_data(mem_data)
  );

  // RAM: combinational read while strobed, level-sensitive write sampled mid-cycle
  assign mem_data = o_mem_read ? ram[o_mem_addr[7:0]] : {DW{1'bz}};
  always @(negedge clock) if (o_mem_write) ram[o_mem_addr[7:0]] = mem_data;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each granted access occupies m_len cycles after its IDLE
  // cycle (2 read, 4 store, 1 out-of-range); the ack shows in the last one.
  int            m_phase = 0;
  int            m_len = 0;
  int            m_streak = 0;
  bit            m_port_d = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] e_if_rdata = '0;
  logic [DW-1:0] e_d_rdata = '0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_phase = 0; m_len = 0; m_streak = 0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      if (m_phase == 0) begin
        if (d_req || if_req) begin
          m_port_d = d_req && !(if_req && m_streak == MAXS);
          m_addr   = m_port_d ? d_addr : if_addr;
          m_wdata  = d_wdata;
          m_err    = int'(m_addr) >= DEPTH;
          m_len    = m_err ? 1 : ((m_port_d && d_we) ? 4 : 2);
          m_phase  = 1;
          m_streak = (m_port_d && if_req) ? m_streak + 1 : 0;
          if (m_len == 4) ref_mem[m_addr[7:0]] = m_wdata;
        end else begin
          m_streak = 0;
        end
      end else begin
        if (!if_req) m_streak = 0;
        m_phase = (m_phase == m_len) ? 0 : m_phase + 1;
      end
      if (m_phase != 0 && m_phase == m_len) begin
        if (m_err) begin
          if (m_port_d) e_d_rdata = '0; else e_if_rdata = '0;
        end else if (m_len == 2) begin
          if (m_port_d) e_d_rdata = ref_mem[m_addr[7:0]];
          else          e_if_rdata = ref_mem[m_addr[7:0]];
        end
      end
    end
  end

  always @(negedge clock) begin
    bit rd_ph, wr_ph, ack_ph;
    rd_ph  = (m_phase == 1 && m_len == 2);
    wr_ph  = (m_len == 4 && m_phase >= 1 && m_phase <= 3);
    ack_ph = (m_phase != 0 && m_phase == m_len);
    if (o_mem_read)  n_rd++;
    if (o_mem_write) n_wr++;
    chk1("mem_read", o_mem_read, rd_ph);
    chk1("mem_write", o_mem_write, m_len == 4 && m_phase == 2);
    chk1("rw_exclusive", o_mem_read && o_mem_write, 1'b0);
    chk1("if_ack", o_if_ack, ack_ph && !m_port_d);
    chk1("d_ack", o_d_ack, ack_ph && m_port_d);
    if (ack_ph && m_port_d)  chk1("d_err", o_d_err, m_err);
    if (ack_ph && !m_port_d) chk1("if_err", o_if_err, m_err);
    chk32("if_rdata", o_if_rdata, e_if_rdata);
    chk32("d_rdata", o_d_rdata, e_d_rdata);
    if (rd_ph || wr_ph) chk32("mem_addr", 32'(o_mem_addr), 32'(m_addr));
    if (wr_ph) chk32("mem_data_write", mem_data, m_wdata);
    if (rd_ph) chk32("mem_data_read", mem_data, ref_mem[m_addr[7:0]]);
  end

  task automatic wait_ack(input bit pd, output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(pd ? o_d_ack : o_if_ack) && lat < 30);
    if (!(pd ? o_d_ack : o_if_ack)) begin
      checks++; errors++;
      $display("FAIL ack_timeout: port_d=%0d no ack after %0d cycles, required one", pd, lat);
    end
  endtask

  // Returns cycles from IDLE (grant) cycle to ack plus one, plus ack-time err/rdata.
  task automatic do_access(input bit pd, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input bit keep,
                           output int lat, output logic err, output logic [DW-1:0] rdata);
    @(posedge clock); #1;
    if (pd) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin if_req = 1'b1; if_addr = a; end
    wait_ack(pd, lat);
    err   = pd ? o_d_err : o_if_err;
    rdata = pd ? o_d_rdata : o_if_rdata;
    if (!keep) begin
      if (pd) d_req = 1'b0; else if_req = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return AW'(256 + $urandom_range(0, 255));
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, 255));
  endfunction

  initial begin
    int            lat, rd0, wr0, nacc, cnt;
    logic          e;
    logic [DW-1:0] rd;
    logic [31:0]   order;

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    ram[0]  = 32'h4880_0023;
    ram[85] = 32'hFFFF_0000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("rst_mem_read", o_mem_read, 1'b0);
    chk1("rst_mem_write", o_mem_write, 1'b0);
    chk32("rst_mem_addr", 32'(o_mem_addr), 32'h0);
    chk1("rst_if_ack", o_if_ack, 1'b0);
    chk32("rst_d_rdata", o_d_rdata, 32'h0);
    clear = 1'b0;

    // fetch of word 0
    rd0 = n_rd;
    do_access(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, lat, e, rd);
    chk32("fetch_ack_latency", lat - 1, 2);
    chk32("fetch_rdata", rd, 32'h4880_0023);
    chk1("fetch_err", e, 1'b0);
    chk32("fetch_read_cycles", n_rd - rd0, 1);

    // store then load address 85
    wr0 = n_wr;
    do_access(1'b1, 1'b1, 9'd85, 32'h0000_0002, 1'b0, lat, e, rd);
    chk32("store_ack_latency", lat - 1, 4);
    chk32("store_write_cycles", n_wr - wr0, 1);
    chk1("store_err", e, 1'b0);
    do_access(1'b1, 1'b0, 9'd85, 32'h0, 1'b0, lat, e, rd);
    chk32("load_ack_latency", lat - 1, 2);
    chk32("load_rdata", rd, 32'h0000_0002);

    // both requesters held continuously
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = 9'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd85;
    nacc = 0; order = '0;
    for (int k = 0; k < 100 && nacc < 10; k++) begin
      @(negedge clock);
      if (o_d_ack || o_if_ack) begin
        order = {order[30:0], o_d_ack};
        nacc++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk32("grant_count", nacc, 10);
    chk32("grant_order", order, 32'b11110_11110);

    // out-of-range load and store
    rd0 = n_rd; wr0 = n_wr;
    do_access(1'b1, 1'b0, 9'h100, 32'h0, 1'b0, lat, e, rd);
    chk1("oor_load_err", e, 1'b1);
    chk32("oor_load_rdata", rd, 32'h0);
    chk32("oor_load_latency", lat - 1, 1);
    do_access(1'b1, 1'b1, 9'h100, 32'hDEAD_BEEF, 1'b0, lat, e, rd);
    chk1("oor_store_err", e, 1'b1);
    chk32("oor_strobes", (n_rd - rd0) + (n_wr - wr0), 0);
    chk32("oor_ram_unchanged", ram[0], 32'h4880_0023);

    // clear during the write pulse
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd85; d_wdata = 32'h0000_0077;
    for (int k = 0; k < 10 && !o_mem_write; k++) @(negedge clock);
    chk1("clr_reached_wpulse", o_mem_write, 1'b1);
    #1 clear = 1'b1; d_req = 1'b0;
    #1;
    chk1("clr_write_async", o_mem_write, 1'b0);
    chk1("clr_read", o_mem_read, 1'b0);
    chk1("clr_d_ack", o_d_ack, 1'b0);
    #1 clear = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clock); if (o_d_ack) cnt++; end
    chk32("clr_no_ack", cnt, 0);
    do_access(1'b1, 1'b0, 9'd85, 32'h0, 1'b0, lat, e, rd);
    chk32("clr_next_latency", lat - 1, 2);
    chk32("clr_next_rdata", rd, 32'h0000_0077);

    // request held past its ack is served again
    do_access(1'b1, 1'b0, 9'd0, 32'h0, 1'b1, lat, e, rd);
    wait_ack(1'b1, lat);
    chk32("rereq_latency", lat, 3);
    d_req = 1'b0;

    // randomized traffic, reference model checks every cycle
    repeat (1500) begin
      @(posedge clock); #1;
      if (o_if_ack) begin
        if ($urandom_range(0, 5) != 0) if_req = 1'b0;
      end else if (if_req) begin
        if (m_phase >= 1 && !m_port_d && $urandom_range(0, 3) == 0) if_addr = rnd_addr();
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      if (o_d_ack) begin
        if ($urandom_range(0, 5) != 0) d_req = 1'b0;
      end else if (d_req) begin
        if (m_phase >= 1 && m_port_d && $urandom_range(0, 3) == 0) begin
          d_addr = rnd_addr(); d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 2) == 0;
        d_addr = rnd_addr(); d_wdata = $urandom;
      end
    end
    for (int k = 0; k < 40 && (if_req || d_req); k++) begin
      @(posedge clock); #1;
      if (o_if_ack) if_req = 1'b0;
      if (o_d_ack)  d_req = 1'b0;
    end
    chk1("drain_if_req", if_req, 1'b0);
    chk1("drain_d_req", d_req, 1'b0);
    repeat (6) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
